// File: rtl/fpga_mode_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpga_mode_pkg
// Description : Shared types and constants for the FPGA mode switch.
// Revision    : 1.0 - initial release
// ============================================================================
package fpga_mode_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        QUIESCE = 2'd1,
        SWITCH  = 2'd2,
        SETTLE  = 2'd3
    } state_t;

    localparam int MODE_HF = 0;
    localparam int MODE_LF = 1;

    localparam logic [63:0] SAFE_VAL_DEFAULT = 64'd0;

    // Width that holds the largest of the three interval counts without wrapping.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fpga_mode_switch_if.sv
`default_nettype none
// ============================================================================
// Module      : fpga_mode_switch_if
// Description : Pin/core-side signal bundle of the FPGA mode switch.
// Revision    : 1.0 - initial release
// ============================================================================
interface fpga_mode_switch_if #(
    parameter int NUM_MODES = 2,
    parameter int OUT_W     = 16,
    parameter int IN_W      = 8,
    parameter int SEL_W     = $clog2(NUM_MODES)
) ();
    logic [SEL_W-1:0]          mode_req;
    logic [NUM_MODES*OUT_W-1:0] mod_out;
    logic [IN_W-1:0]           pin_in;
    logic [OUT_W-1:0]          pin_out;
    logic [NUM_MODES*IN_W-1:0] mod_in;
    logic [NUM_MODES-1:0]      mod_en;
    logic [SEL_W-1:0]          mode_cur;
    logic                      switching;
    logic                      err_bad_mode;

    modport slave (
        input  mode_req, mod_out, pin_in,
        output pin_out, mod_in, mod_en, mode_cur, switching, err_bad_mode
    );

    modport master (
        output mode_req, mod_out, pin_in,
        input  pin_out, mod_in, mod_en, mode_cur, switching, err_bad_mode
    );
endinterface
`default_nettype wire

// File: rtl/fpga_mode_switch_sync_debounce.sv
`default_nettype none
// ============================================================================
// Module      : mode_req_sync_debounce
// Description : 2-flop synchroniser plus debounce of the mode request; emits a
//               one-cycle acceptance pulse with the accepted value.
// Revision    : 1.0 - initial release
// ============================================================================
module mode_req_sync_debounce #(
    parameter int SEL_W        = 1,
    parameter int DEBOUNCE_CYC = 64
) (
    input  wire logic             ck_1356meg,
    input  wire logic             reset,
    input  wire logic [SEL_W-1:0] mode_req,
    output logic                  acc_vld,
    output logic [SEL_W-1:0]      acc_val
);
    logic [SEL_W-1:0] meta_q;
    logic [SEL_W-1:0] sync_q;
    logic [SEL_W-1:0] prev_q;
    logic             change;

    always_ff @(posedge ck_1356meg or posedge reset) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            meta_q <= mode_req;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign change  = (sync_q != prev_q);
    assign acc_val = sync_q;

    generate
        if (DEBOUNCE_CYC > 1) begin : g_debounce
            localparam int DW = $clog2(DEBOUNCE_CYC + 1);
            logic [DW-1:0] stable_q, stable_d;
            logic          armed_q, armed_d;
            logic          accept;

            // stable_d counts cycles the candidate has held, including this one.
            always_comb begin
                if (change)
                    stable_d = DW'(1);
                else if (stable_q == DW'(DEBOUNCE_CYC))
                    stable_d = stable_q;
                else
                    stable_d = stable_q + 1'b1;
                accept  = (change | armed_q) && (stable_d == DW'(DEBOUNCE_CYC));
                armed_d = (change | armed_q) & ~accept;
            end

            always_ff @(posedge ck_1356meg or posedge reset) begin
                if (reset) begin
                    stable_q <= '0;
                    armed_q  <= 1'b0;
                end else begin
                    stable_q <= stable_d;
                    armed_q  <= armed_d;
                end
            end

            assign acc_vld = accept;
        end else begin : g_direct
            assign acc_vld = change;
        end
    endgenerate
endmodule
`default_nettype wire

// File: rtl/fpga_mode_switch.sv
`default_nettype none
// ============================================================================
// Module      : fpga_mode_switch
// Description : Glitch-free pin mux between mode cores with quiesce/settle
//               sequencing. Define MODE_SWITCH_DEBOUNCE_EN to debounce requests.
// Revision    : 1.0 - initial release
// ============================================================================
module fpga_mode_switch
    import fpga_mode_pkg::*;
#(
    parameter int               NUM_MODES    = 2,
    parameter int               OUT_W        = 16,
    parameter int               IN_W         = 8,
    parameter int               SEL_W        = $clog2(NUM_MODES),
    parameter int               RESET_MODE   = MODE_HF,
    parameter logic [OUT_W-1:0] SAFE_VAL     = OUT_W'(SAFE_VAL_DEFAULT),
    parameter int               DEBOUNCE_CYC = 64,
    parameter int               GUARD_CYC    = 256,
    parameter int               SETTLE_CYC   = 32
) (
    input  wire logic         ck_1356meg,
    input  wire logic         reset,
    fpga_mode_switch_if.slave bus
);
    localparam int CNT_W = cnt_width(DEBOUNCE_CYC, GUARD_CYC, SETTLE_CYC);
`ifdef MODE_SWITCH_DEBOUNCE_EN
    localparam int DEB_EFF = DEBOUNCE_CYC;
`else
    localparam int DEB_EFF = 1;
`endif
    localparam logic [SEL_W:0] NUM_MODES_W = (SEL_W + 1)'(NUM_MODES);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SEL_W-1:0]   mode_cur_q, mode_cur_d;
    logic [SEL_W-1:0]   target_q, target_d;
    logic [SEL_W-1:0]   pend_q, pend_d;
    logic               pend_vld_q, pend_vld_d;
    logic               err_q, err_d;
    logic [OUT_W-1:0]   pin_out_q, pin_out_d;
    logic [NUM_MODES-1:0] mod_en_q, mod_en_d;

    logic               acc_vld;
    logic [SEL_W-1:0]   acc_val;
    logic               acc_ok;
    logic               req_vld;
    logic [SEL_W-1:0]   req_sel;

    mode_req_sync_debounce #(
        .SEL_W        (SEL_W),
        .DEBOUNCE_CYC (DEB_EFF)
    ) u_sync_debounce (
        .ck_1356meg (ck_1356meg),
        .reset      (reset),
        .mode_req   (bus.mode_req),
        .acc_vld    (acc_vld),
        .acc_val    (acc_val)
    );

    assign acc_ok = acc_vld && ({1'b0, acc_val} < NUM_MODES_W);

    always_ff @(posedge ck_1356meg or posedge reset) begin
        if (reset) begin
            state_q    <= SETTLE;
            cnt_q      <= CNT_W'(SETTLE_CYC);
            mode_cur_q <= SEL_W'(RESET_MODE);
            target_q   <= SEL_W'(RESET_MODE);
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            err_q      <= 1'b0;
            pin_out_q  <= SAFE_VAL;
            mod_en_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mode_cur_q <= mode_cur_d;
            target_q   <= target_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            err_q      <= err_d;
            pin_out_q  <= pin_out_d;
            mod_en_q   <= mod_en_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mode_cur_d = mode_cur_q;
        target_d   = target_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        err_d      = err_q | (acc_vld & ~acc_ok);
        // A fresh acceptance outranks an older pending request.
        req_vld    = acc_ok | pend_vld_q;
        req_sel    = acc_ok ? acc_val : pend_q;
        case (state_q)
            RUN: begin
                pend_vld_d = 1'b0;
                if (req_vld && (req_sel != mode_cur_q)) begin
                    target_d = req_sel;
                    state_d  = QUIESCE;
                    cnt_d    = CNT_W'(GUARD_CYC);
                end
            end
            QUIESCE: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d    = SWITCH;
                    mode_cur_d = target_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            SWITCH: begin
                state_d = SETTLE;
                cnt_d   = CNT_W'(SETTLE_CYC);
            end
            SETTLE: begin
                if (cnt_q <= CNT_W'(1))
                    state_d = RUN;
                else
                    cnt_d = cnt_q - 1'b1;
            end
            default: begin
                state_d = SETTLE;
                cnt_d   = CNT_W'(SETTLE_CYC);
            end
        endcase
        if ((state_q != RUN) && acc_ok) begin
            pend_vld_d = 1'b1;
            pend_d     = acc_val;
        end
    end

    // Outputs follow the next state so pins and enables change on the same edge.
    always_comb begin
        pin_out_d = SAFE_VAL;
        mod_en_d  = '0;
        if (state_d == RUN)
            pin_out_d = bus.mod_out[int'(mode_cur_d) * OUT_W +: OUT_W];
        if ((state_d == RUN) || (state_d == SETTLE))
            mod_en_d = NUM_MODES'(1) << mode_cur_d;
    end

    generate
        for (genvar i = 0; i < NUM_MODES; i++) begin : g_mod_in
            assign bus.mod_in[i*IN_W +: IN_W] = bus.pin_in & {IN_W{mod_en_q[i]}};
        end
    endgenerate

    assign bus.pin_out      = pin_out_q;
    assign bus.mod_en       = mod_en_q;
    assign bus.mode_cur     = mode_cur_q;
    assign bus.switching    = (state_q != RUN);
    assign bus.err_bad_mode = err_q;
endmodule
`default_nettype wire

// File: tb/tb_fpga_mode_switch.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpga_mode_switch
// Description : Self-checking bench for fpga_mode_switch with a timeline model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpga_mode_switch;
    localparam int NM = 3, OUT_W = 16, IN_W = 8, SEL_W = 2;
    localparam int RESET_MODE = 0, DEB_CFG = 4, GUARD = 6, SETTLE = 5;
    localparam logic [OUT_W-1:0] SAFE = 16'hA5C3;
`ifdef MODE_SWITCH_DEBOUNCE_EN
    localparam int DEB = DEB_CFG;
`else
    localparam int DEB = 1;
`endif
    localparam int PH_RUN = 0, PH_QUIESCE = 1, PH_SWITCH = 2, PH_SETTLE = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fpga_mode_switch_if #(.NUM_MODES(NM), .OUT_W(OUT_W), .IN_W(IN_W), .SEL_W(SEL_W)) bus ();

    fpga_mode_switch #(
        .NUM_MODES(NM), .OUT_W(OUT_W), .IN_W(IN_W), .SEL_W(SEL_W),
        .RESET_MODE(RESET_MODE), .SAFE_VAL(SAFE), .DEBOUNCE_CYC(DEB_CFG),
        .GUARD_CYC(GUARD), .SETTLE_CYC(SETTLE)
    ) dut (
        .ck_1356meg (clk),
        .reset      (rst),
        .bus        (bus)
    );

    int checks = 0;
    int errors = 0;

    // Timeline model: a switch is a window of cycles measured from its start.
    int n, sw_start, m_mode, m_target, m_pend, acc_val, cand_last, last_change;
    bit m_pend_v, m_err, acc_v, seen_change;
    int req_q[$];
    logic [NM*OUT_W-1:0] mout_prev;
    logic [OUT_W-1:0]    exp_pin;
    logic [NM-1:0]       exp_en;
    logic [SEL_W-1:0]    req_drv = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, n);
        end
    endtask

    function automatic int phase_of(input int m);
        int k;
        k = m - sw_start;
        if (k < GUARD) return PH_QUIESCE;
        if (k == GUARD) return PH_SWITCH;
        if (k <= GUARD + SETTLE) return PH_SETTLE;
        return PH_RUN;
    endfunction

    task automatic model_reset();
        n = 0; sw_start = -(GUARD + 1);
        m_mode = RESET_MODE; m_target = RESET_MODE; m_pend_v = 0; m_pend = 0; m_err = 0;
        cand_last = 0; last_change = 0; seen_change = 0; acc_v = 0; acc_val = 0;
        req_q.delete();
        exp_pin = SAFE; exp_en = '0;
    endtask

    task automatic model_step();
        int p, pn, want, c;
        bit has;
        n++;
        p = phase_of(n - 1);
        if (acc_v && acc_val >= NM) m_err = 1;
        if (p == PH_RUN) begin
            has = 0; want = 0;
            if (acc_v && acc_val < NM) begin has = 1; want = acc_val; end
            else if (m_pend_v) begin has = 1; want = m_pend; end
            m_pend_v = 0;
            if (has && want != m_mode) begin m_target = want; sw_start = n; end
        end else if (acc_v && acc_val < NM) begin
            m_pend_v = 1; m_pend = acc_val;
        end
        pn = phase_of(n);
        if (pn == PH_SWITCH) m_mode = m_target;
        exp_pin = (pn == PH_RUN) ? mout_prev[m_mode*OUT_W +: OUT_W] : SAFE;
        exp_en  = (pn == PH_RUN || pn == PH_SETTLE) ? (NM'(1) << m_mode) : '0;
        c = (n >= 2) ? req_q[n-2] : 0;
        if (c != cand_last) begin cand_last = c; last_change = n; seen_change = 1; end
        acc_v   = seen_change && (n - last_change + 1 == DEB);
        acc_val = c;
    endtask

    task automatic check_outputs();
        logic [NM*IN_W-1:0] exp_in;
        for (int i = 0; i < NM; i++) exp_in[i*IN_W +: IN_W] = exp_en[i] ? bus.pin_in : '0;
        chk("pin_out", bus.pin_out, exp_pin);
        chk("mod_en", bus.mod_en, exp_en);
        chk("mode_cur", bus.mode_cur, 64'(m_mode));
        chk("switching", bus.switching, 64'(phase_of(n) != PH_RUN));
        chk("err_bad_mode", bus.err_bad_mode, 64'(m_err));
        chk("mod_in", bus.mod_in, exp_in);
    endtask

    task automatic apply_inputs();
        bus.mode_req = req_drv;
        bus.mod_out  = (NM*OUT_W)'({$urandom(), $urandom()});
        bus.pin_in   = IN_W'($urandom());
        req_q.push_back(int'(req_drv));
        mout_prev = bus.mod_out;
    endtask

    task automatic step();
        @(negedge clk);
        model_step();
        check_outputs();
        apply_inputs();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pin_out"}, bus.pin_out, SAFE);
        chk({tag, "_mod_en"}, bus.mod_en, '0);
        chk({tag, "_mode_cur"}, bus.mode_cur, RESET_MODE);
        chk({tag, "_switching"}, bus.switching, 1);
        chk({tag, "_err"}, bus.err_bad_mode, 0);
        chk({tag, "_mod_in"}, bus.mod_in, '0);
    endtask

    task automatic do_reset(input int hold);
        @(negedge clk);
        rst = 1'b1;
        #1 chk_reset_vals("rst_async");
        repeat (hold) @(negedge clk);
        chk_reset_vals("rst_held");
        rst = 1'b0;
        model_reset();
        check_outputs();
        apply_inputs();
    endtask

    task automatic wait_switching(input string name);
        for (int k = 0; k < 60 && !bus.switching; k++) step();
        chk(name, bus.switching, 1);
    endtask

    typedef struct {
        logic [SEL_W-1:0] req;
        int               hold;
        logic [SEL_W-1:0] exp_mode;
        logic             exp_err;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_run;
        bit seen;
        bus.mode_req = '0; bus.mod_out = '0; bus.pin_in = '0;
        vecs = '{'{2'd1, 40, 2'd1, 1'b0},
                 '{2'd2, 40, 2'd2, 1'b0},
                 '{2'd3, 40, 2'd2, 1'b1},
                 '{2'd0, 40, 2'd0, 1'b1},
                 '{2'd1, 40, 2'd1, 1'b1}};

        do_reset(2);
        first_run = -1;
        for (int k = 0; k < SETTLE + 4; k++) begin
            step();
            if (!bus.switching && first_run < 0) first_run = n;
        end
        chk("run_after_reset", first_run, SETTLE);

        for (int i = 0; i < 5; i++) begin
            req_drv = vecs[i].req;
            repeat (vecs[i].hold) step();
            chk("vec_mode_cur", bus.mode_cur, vecs[i].exp_mode);
            chk("vec_err", bus.err_bad_mode, vecs[i].exp_err);
        end

`ifdef MODE_SWITCH_DEBOUNCE_EN
        // A pulse shorter than the debounce window must never start a switch.
        seen = 0;
        req_drv = 2'd0;
        repeat (DEB - 1) begin step(); seen |= bus.switching; end
        req_drv = 2'd1;
        repeat (30) begin step(); seen |= bus.switching; end
        chk("glitch_no_switch", seen, 0);
`endif

        // Request arriving mid-switch is honoured after the first one settles.
        req_drv = 2'd2;
        wait_switching("wait_switch_pend");
        req_drv = 2'd0;
        seen = 0;
        repeat (60) begin step(); seen |= (bus.mode_cur == 2'd2); end
        chk("pend_passed_mode2", seen, 1);
        chk("pend_final_mode", bus.mode_cur, 0);

        // Reset in the middle of the guard interval.
        req_drv = 2'd1;
        wait_switching("wait_switch_rst");
        repeat (2) step();
        chk("midq_mod_en", bus.mod_en, '0);
        do_reset(1);
        repeat (40) step();
        chk("post_rst_mode", bus.mode_cur, 1);

        for (int r = 0; r < 40; r++) begin
            req_drv = SEL_W'($urandom_range(0, 3));
            repeat ($urandom_range(1, 25)) step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/fpga_mode_switch.md
# fpga_mode_switch

Sequential, glitch-free mode selector that sits at the FPGA top level between the device pins and NUM_MODES mode cores (HF, LF, and future modes). It replaces a bare combinational select with these steps:
- synchronise and debounce the external mode request;
- quiesce every pin output to a safe value and gate off all cores for a guard interval;
- switch the shared pins to the new core;
- let the new core settle before its outputs reach the pins.

## Interface
Parameters:
- NUM_MODES, 2, number of mode cores (≥2)
- OUT_W, 16, pin-output bits multiplexed from each core
- IN_W, 8, shared pin-input bits fanned out to each core
- SEL_W, $clog2(NUM_MODES), mode index width (derived)
- RESET_MODE, 0, mode active after reset (< NUM_MODES)
- SAFE_VAL, OUT_W'b0, value driven on pin_out while quiesced (all power/oe off)
- DEBOUNCE_CYC, 64, cycles a synchronised request must be stable (≥1)
- GUARD_CYC, 256, quiesce cycles before select changes (≥1)
- SETTLE_CYC, 32, cycles new core runs before pins are released (≥1)

Ports:
- ck_1356meg  in  1  clock
- reset  in  1  asynchronous, active-high reset
- mode_req  in  SEL_W  asynchronous mode request (FPGA_SWITCH pins)
- mod_out  in  NUM_MODES*OUT_W  core outputs, core i at [i*OUT_W +: OUT_W]
- pin_in  in  IN_W  shared pin inputs
- pin_out  out  OUT_W  registered pin outputs
- mod_in  out  NUM_MODES*IN_W  per-core inputs; pin_in for the enabled core, zero otherwise
- mod_en  out  NUM_MODES  one-hot core enable, all-zero while quiesced
- mode_cur  out  SEL_W  currently selected mode
- switching  out  1  high in every state except RUN
- err_bad_mode  out  1  sticky; set when a debounced request ≥ NUM_MODES

## Operation
- Sync: mode_req passes through a 2-flop synchroniser (all bits; the debounce filters skew).
- Debounce: the candidate is the synchronised value. A counter reloads on any candidate change. The request is accepted once the candidate has been stable DEBOUNCE_CYC consecutive cycles. Acceptance is re-armed only after the candidate changes.
- Accepted value handling:
  - ≥ NUM_MODES: ignored; err_bad_mode is set.
  - equal to mode_cur: no action.
  - otherwise: latched as target, and the FSM leaves RUN.
- States:
  - RUN: pin_out tracks the selected core; mod_en is one-hot for mode_cur.
  - QUIESCE: pin_out = SAFE_VAL; mod_en = 0; runs for GUARD_CYC cycles.
  - SWITCH: mode_cur ← target for 1 cycle; outputs are still quiesced.
  - SETTLE: mod_en is one-hot for the new mode; pin_out = SAFE_VAL; runs for SETTLE_CYC cycles, then returns to RUN.
- Requests accepted outside RUN are held in a one-deep pending register, newest wins. In RUN, a pending target ≠ mode_cur starts a new switch immediately. A pending target equal to mode_cur is dropped.
- mod_in[i] = pin_in & {IN_W{mod_en[i]}}. This is combinational from registered mod_en.
- Counter width: $clog2(max(DEBOUNCE_CYC, GUARD_CYC, SETTLE_CYC)+1). Counters saturate and never wrap.

## Timing
Reset values:
- state = SETTLE, counter = SETTLE_CYC
- mode_cur = RESET_MODE
- pin_out = SAFE_VAL
- mod_en = 0
- switching = 1
- err_bad_mode = 0
- pending empty; synchroniser flops 0

After reset:
- mod_en becomes one-hot RESET_MODE at the first edge after reset deasserts.
- RUN is reached SETTLE_CYC cycles after deassertion.

Latencies:
- pin_out in RUN lags mod_out by one cycle (registered).
- Switch latency: mode_req change → 2 sync → DEBOUNCE_CYC → QUIESCE next edge → GUARD_CYC → 1 SWITCH → SETTLE_CYC → RUN.
- pin_out and mod_en change on the same edge on QUIESCE entry, so no cycle drives pins from a disabled core.

Other rules:
- Reset mid-switch aborts to the reset state immediately (async). Target and pending are discarded.
- Simultaneous acceptance and FSM exit from SETTLE: the request is captured in pending and honoured in the first RUN cycle.

## Configuration
- MODE_SWITCH_DEBOUNCE_EN defined: debounce as above.
- Undefined: the synchronised value is accepted on the cycle after it changes (effective DEBOUNCE_CYC = 1). The debounce counter is not built. All other behaviour is unchanged.

## Structure
- Package fpga_mode_pkg:
  - state enum: RUN, QUIESCE, SWITCH, SETTLE
  - mode constants: MODE_HF = 0, MODE_LF = 1
  - default SAFE_VAL
- Sub-module mode_req_sync_debounce:
  - function: synchroniser, debounce, acceptance pulse with value
  - parameters: SEL_W, DEBOUNCE_CYC
- Top holds the FSM, pending register, output registers and gating.

## Test plan
- Reset release, RESET_MODE=0, SETTLE_CYC=32 → pin_out=SAFE_VAL and mod_en=0b01 for 32 cycles, then RUN with pin_out = core0 output one cycle later.
- mode_req 0→1 held, DEBOUNCE_CYC=64, GUARD_CYC=256 → mod_en=0 and pin_out=SAFE_VAL for exactly 256 cycles, mode_cur=1 after SWITCH, RUN 32 cycles later; never a cycle with core1 output while mod_en[1]=0.
- mode_req pulses to 1 for 10 cycles, then back to 0 → no acceptance, switching stays 0.
- NUM_MODES=3, mode_req=3 held → err_bad_mode=1 sticky, mode_cur unchanged, no QUIESCE.
- During QUIESCE 0→1, request 2 accepted → after settling in mode 1, immediately QUIESCE again and end in mode_cur=2.
- reset asserted mid-QUIESCE → next cycle state SETTLE, mode_cur=RESET_MODE, pending cleared.
